dpram_fifo_ctrl: RTL and testbench

- Sequencing controller that turns the 256x32 simple dual-port RAM (write port, registered read port, 1-clock read latency, unpredictable mixed-port read-during-write) into a streaming FIFO with valid/ready on both sides.
- Owns the write and read pointers and the occupancy count.
- Hides the RAM read latency behind a 2-entry output skid buffer, so sustained throughput is 1 word/clock.
- Sits between a producer such as the Avalon-ST ingress and a consumer; the RAM instance stays outside the block.

---
 rtl/dpram_fifo_ctrl.sv | 121 ++++++++++++
 tb/tb_dpram_fifo_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - streaming FIFO controller around an external 1-clock-latency dual-port RAM
module dpram_fifo_ctrl #(
  parameter int DW    = 32,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [AW+1:0] level,
  output logic [AW-1:0] ram_wraddress,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  output logic [AW-1:0] ram_rdaddress,
  input  logic [DW-1:0] ram_q
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  // RAM-side bookkeeping; ram_count only counts words whose write edge has passed
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   ram_count;
  logic          inflight;

  // two-entry skid buffer, buf0 is always the head
  logic [1:0]    buf_cnt;
  logic [DW-1:0] buf0;
  logic [DW-1:0] buf1;
  logic [AW+1:0] level_q;

  logic          push;
  logic          pop;
  logic          issue;
  logic [1:0]    buf_after_pop;
  logic [AW:0]   ram_count_next;
  logic [1:0]    buf_cnt_next;
  logic [DW-1:0] buf0_next;
  logic [DW-1:0] buf1_next;
  logic [AW+1:0] level_next;

  // handshakes and RAM port drive; in_ready never looks at out_ready
  always_comb begin
    in_ready      = (ram_count < FULL) & ~flush;
    push          = in_valid & in_ready;
    out_valid     = (buf_cnt != 2'd0);
    out_data      = buf0;
    pop           = out_valid & out_ready;
    ram_wren      = push;
    ram_wraddress = wr_ptr;
    ram_data      = in_data;
    ram_rdaddress = rd_ptr;
    level         = level_q;
  end

  // read issue: only when the word will have a free buffer slot on return
  always_comb begin
    buf_after_pop  = buf_cnt - {1'b0, pop};
    issue          = (ram_count != '0) & ((buf_after_pop + {1'b0, inflight}) < 2'd2) & ~flush;
    ram_count_next = ram_count + (AW+1)'(push) - (AW+1)'(issue);
    buf_cnt_next   = buf_after_pop + {1'b0, inflight};
    level_next     = (AW+2)'(ram_count_next) + (AW+2)'(issue) + (AW+2)'(buf_cnt_next);
  end

  // skid buffer next state: shift head on pop, land the returning word at the tail
  always_comb begin
    buf0_next = buf0;
    buf1_next = buf1;
    if (pop) begin
      buf0_next = buf1;
    end
    if (inflight) begin
      if (buf_after_pop == 2'd0) begin
        buf0_next = ram_q;
      end else begin
        buf1_next = ram_q;
      end
    end
  end

  // pointer, count and in-flight state; reset and flush drop any outstanding read
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      inflight  <= 1'b0;
      level_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      ram_count <= ram_count_next;
      inflight  <= issue;
      level_q   <= level_next;
    end
  end

  // skid buffer registers
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      buf_cnt <= 2'd0;
      buf0    <= '0;
      buf1    <= '0;
    end else begin
      buf_cnt <= buf_cnt_next;
      buf0    <= buf0_next;
      buf1    <= buf1_next;
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb/tb_dpram_fifo_ctrl.sv - randomized and directed bench for dpram_fifo_ctrl against a queue model
module tb_dpram_fifo_ctrl;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [9:0]  level;
  logic [7:0]  ram_wraddress;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [7:0]  ram_rdaddress;
  logic [31:0] ram_q;

  dpram_fifo_ctrl #(.DW(32), .AW(8), .DEPTH(256)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .level(level),
    .ram_wraddress(ram_wraddress), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_rdaddress(ram_rdaddress), .ram_q(ram_q)
  );

  logic [31:0] mem [256];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    ram_q <= mem[ram_rdaddress];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_acc    = 0;
  int          n_pop    = 0;
  logic [31:0] model_q [$];
  logic        chk_en    = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] seq       = 32'h1000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // one clock: drive at negedge, sample 1ns later, then update the word-level model
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy,
                      input logic fl, input logic rs);
    @(negedge clock);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; reset = rs;
    #1;
    if (chk_en) begin
      check("level", 64'(level), 64'(model_q.size()));
      if (!rs && !fl && model_q.size() < 256) check("in_ready_open", 64'(in_ready), 64'd1);
      if (model_q.size() >= 258) check("in_ready_full", 64'(in_ready), 64'd0);
      if (prev_hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(out_data), 64'(prev_data));
      end
      if (model_q.size() == 0) check("spurious_valid", 64'(out_valid), 64'd0);
      if (out_valid && ordy && !rs && !fl && model_q.size() > 0)
        check("order", 64'(out_data), 64'(model_q[0]));
    end
    if (rs || fl) begin
      model_q.delete();
    end else begin
      if (out_valid && ordy && model_q.size() > 0) begin
        void'(model_q.pop_front());
        n_pop++;
      end
      if (iv && in_ready) begin
        model_q.push_back(d);
        n_acc++;
      end
    end
    prev_hold = out_valid && !ordy && !fl && !rs;
    prev_data = out_data;
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 700 && model_q.size() > 0; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("drained", 64'(model_q.size()), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("drained_valid", 64'(out_valid), 64'd0);
  endtask

  // leave a read in flight with a word buffered, then clear via flush or reset
  task automatic clear_case(input logic use_rst);
    step(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hA3, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, ~use_rst, use_rst);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("clr_valid", 64'(out_valid), 64'd0);
    check("clr_ready", 64'(in_ready), 64'd1);
    check("clr_data", 64'(out_data), 64'd0);
    check("clr_wren", 64'(ram_wren), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("clr_stale", 64'(out_valid), 64'd0);
    end
    step(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0);
    check("clr_wraddr", 64'(ram_wraddress), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("clr_rdaddr", 64'(ram_rdaddress), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("clr_rdaddr_inc", 64'(ram_rdaddress), 64'd1);
    check("clr_not_yet", 64'(out_valid), 64'd0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("clr_out_valid", 64'(out_valid), 64'd1);
    check("clr_out_data", 64'(out_data), 64'h12345678);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    do_reset();
    chk_en = 1'b1;

    // reset state
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_wren", 64'(ram_wren), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);

    // single-word latency
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    check("lat_wren", 64'(ram_wren), 64'd1);
    check("lat_wraddr", 64'(ram_wraddress), 64'd0);
    check("lat_wdata", 64'(ram_data), 64'hDEADBEEF);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("lat_rdaddr", 64'(ram_rdaddress), 64'd0);
    check("lat_c1_valid", 64'(out_valid), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("lat_issued", 64'(ram_rdaddress), 64'd1);
    check("lat_c2_valid", 64'(out_valid), 64'd0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("lat_c3_valid", 64'(out_valid), 64'd1);
    check("lat_c3_data", 64'(out_data), 64'hDEADBEEF);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("lat_empty", 64'(out_valid), 64'd0);

    // 1000-word stream at full rate
    begin
      int base_pop;
      logic started;
      do_reset();
      base_pop = n_pop;
      started = 1'b0;
      for (int i = 0; i < 1010; i++) begin
        int remaining;
        remaining = 1000 - (n_pop - base_pop);
        step(i < 1000, 32'(i), 1'b1, 1'b0, 1'b0);
        if (i < 1000) check("stream_ready", 64'(in_ready), 64'd1);
        if (started && remaining > 0) check("stream_no_gap", 64'(out_valid), 64'd1);
        if (out_valid) started = 1'b1;
      end
      check("stream_count", 64'(n_pop - base_pop), 64'd1000);
    end

    // fill to capacity with the consumer stalled
    begin
      int base_acc;
      do_reset();
      base_acc = n_acc;
      for (int i = 0; i < 300; i++) begin
        step(1'b1, seq, 1'b0, 1'b0, 1'b0);
        seq++;
      end
      check("fill_accepted", 64'(n_acc - base_acc), 64'd258);
      check("fill_level", 64'(level), 64'd258);
      check("fill_ready", 64'(in_ready), 64'd0);

      // single pop frees exactly one slot
      step(1'b1, seq, 1'b1, 1'b0, 1'b0);
      seq++;
      base_acc = n_acc;
      step(1'b1, seq, 1'b0, 1'b0, 1'b0);
      check("pulse_ready", 64'(in_ready), 64'd1);
      seq++;
      for (int i = 0; i < 6; i++) begin
        step(1'b1, seq, 1'b0, 1'b0, 1'b0);
        seq++;
      end
      check("pulse_one_accept", 64'(n_acc - base_acc), 64'd1);
      check("pulse_level", 64'(level), 64'd258);
      drain();
    end

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), seq, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      seq++;
    end
    drain();

    // mid-operation clears
    clear_case(1'b0);
    clear_case(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
